// File: rtl/rsa_host_ctrl.sv
// Host sequencer for the modexp core: loads M/E/P, derives Const = 2^CONST_EXP mod M, runs the core, returns C.
// Latency: 1 cycle CHECK + CONST_EXP cycles CONST + core time in RUN + 1 cycle to out_valid; error path 2 cycles.
// Backpressure: in_ready only in LOAD; RESULT holds out_data/out_err until out_ready, no operands taken meanwhile.
module rsa_host_ctrl #(
    parameter int WIDTH     = 8,
    parameter int CONST_EXP = 2 * (WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             rsa_en,
    output logic [WIDTH-1:0] rsa_P,
    output logic [WIDTH-1:0] rsa_E,
    output logic [WIDTH-1:0] rsa_M,
    output logic [WIDTH-1:0] rsa_Const,
    input  logic [WIDTH-1:0] rsa_C,
    input  logic             rsa_eoc
);

    localparam int IW = $clog2(CONST_EXP + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CHECK,
        S_CONST,
        S_RUN,
        S_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] const_q, const_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;

    // acc stays below M, so doubling fits in WIDTH+1 bits and one conditional
    // subtract keeps it reduced.
    logic [WIDTH:0]   acc_dbl;
    logic [WIDTH:0]   acc_nxt;
    logic             op_bad;

    // One step of the doubling reduction and the operand sanity check.
    always_comb begin
        acc_dbl = {acc_q[WIDTH-1:0], 1'b0};
        acc_nxt = (acc_dbl >= {1'b0, m_q}) ? (acc_dbl - {1'b0, m_q}) : acc_dbl;
        op_bad  = (m_q[0] == 1'b0) || (m_q < WIDTH'(3)) || (p_q >= m_q);
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        iter_d     = iter_q;
        acc_d      = acc_q;
        m_d        = m_q;
        e_d        = e_q;
        p_d        = p_q;
        const_d    = const_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    case (wcnt_q)
                        2'd0:    m_d = in_data;
                        2'd1:    e_d = in_data;
                        default: p_d = in_data;
                    endcase
                    if (wcnt_q == 2'd2) begin
                        wcnt_d  = 2'd0;
                        state_d = S_CHECK;
                    end else begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
            end
            S_CHECK: begin
                if (op_bad) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = S_RESULT;
                end else begin
                    acc_d   = (WIDTH+1)'(1);
                    iter_d  = '0;
                    state_d = S_CONST;
                end
            end
            S_CONST: begin
                acc_d  = acc_nxt;
                iter_d = iter_q + IW'(1);
                // Last iteration: the counter reaches CONST_EXP on this edge.
                if (iter_q == IW'(CONST_EXP - 1)) begin
                    const_d = acc_nxt[WIDTH-1:0];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rsa_eoc) begin
                    out_data_d = rsa_C;
                    out_err_d  = 1'b0;
                    state_d    = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State and datapath registers; reset also discards a partial operand set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            wcnt_q     <= '0;
            iter_q     <= '0;
            acc_q      <= '0;
            m_q        <= '0;
            e_q        <= '0;
            p_q        <= '0;
            const_q    <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            iter_q     <= iter_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            e_q        <= e_d;
            p_q        <= p_d;
            const_q    <= const_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    // Handshake and enable outputs decode straight from the state register, so
    // an asynchronous reset drops them immediately. RESULT always passes through
    // LOAD before RUN, so rsa_en is low for at least one cycle between runs.
    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q != S_LOAD);
    assign out_valid = (state_q == S_RESULT);
    assign rsa_en    = (state_q == S_RUN);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign rsa_M     = m_q;
    assign rsa_E     = e_q;
    assign rsa_P     = p_q;
    assign rsa_Const = const_q;

endmodule
